// File: rtl/edge_pkg.sv
// Shared types and constants for the window fetcher.
// Window geometry is fixed at 5 rows x 4 columns; windows step by 4 pixels
// in both directions, so the bottom row of one window overlaps the top row
// of the window below it.
package edge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    PRESENT = 3'd2,
    ADVANCE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int WIN_ROWS  = 5;
  localparam int WIN_COLS  = 4;
  localparam int WIN_SLOTS = WIN_ROWS * WIN_COLS;
  localparam int TILE_STEP = 4;
  localparam int SLOT_W    = 5;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WIN_SLOTS - 1);

  typedef logic [7:0] pixel_t;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear, enable and programmable
// rollover value. Counts 0..rollover_val and wraps to 0.
// o_rollover_flag is high in the cycle whose increment wraps the count.
module flex_counter #(
  parameter int NUM_BITS = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_count_enable,
  input  logic [NUM_BITS-1:0] i_rollover_val,
  output logic [NUM_BITS-1:0] o_count_out,
  output logic                o_rollover_flag
);

  logic [NUM_BITS-1:0] r_count;

  // Count register: clear wins over enable, wrap at the rollover value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_enable) begin
      r_count <= (r_count == i_rollover_val) ? '0 : r_count + 1'b1;
    end
  end

  assign o_count_out     = r_count;
  assign o_rollover_flag = i_count_enable && (r_count == i_rollover_val);

endmodule

// File: rtl/window_addr_gen.sv
// Combinational address generator for one window slot.
// slot s maps to row r = s / 4 and column c = s % 4 of the window whose
// top-left pixel is (anchor_x, anchor_y). Address arithmetic wraps modulo
// 2^ADDR_W.
// Build option WINDOW_CLAMP_EN: rows below the image are clamped to the
// last image row and still produce a real read (o_in_range always 1).
// Without it, o_in_range drops for those rows and the caller skips them.
module window_addr_gen
  import edge_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 20
) (
  input  logic [31:0]       i_anchor_x,
  input  logic [31:0]       i_anchor_y,
  input  logic [SLOT_W-1:0] i_slot,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_in_range
);

  logic [31:0] w_row;
  logic [31:0] w_col;
  logic [31:0] w_x;
  logic [31:0] w_y;
  logic [31:0] w_y_eff;
  logic        w_y_valid;

  // Slot -> (x, y) -> byte address, with optional bottom-row clamp.
  always_comb begin
    w_row     = 32'(i_slot) / 32'(WIN_COLS);
    w_col     = 32'(i_slot) % 32'(WIN_COLS);
    w_x       = i_anchor_x + w_col;
    w_y       = i_anchor_y + w_row;
    w_y_valid = (w_y < 32'(IMG_H));
`ifdef WINDOW_CLAMP_EN
    w_y_eff    = w_y_valid ? w_y : 32'(IMG_H - 1);
    o_in_range = 1'b1;
`else
    w_y_eff    = w_y;
    o_in_range = w_y_valid;
`endif
    o_mem_addr = i_base_addr + ADDR_W'(w_y_eff * 32'(IMG_W) + w_x);
  end

endmodule

// File: rtl/window_fetcher.sv
// Window fetcher: walks a 5x4 pixel window across a row-major image one
// byte read at a time, presents each full window to the blur stage and
// waits for filter_final before moving on.
// Build option WINDOW_CLAMP_EN selects bottom-row clamping (real reads of
// the last image row) instead of zero-filling rows below the image.
//
// Memory handshake: a read transfers on every rising edge where mem_req
// and mem_ready are both high; mem_data is valid in that same cycle.
// Once raised, mem_req and mem_addr hold their values until that transfer.
module window_fetcher
  import edge_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              mem_ready,
  output logic [159:0]      win_pixels,
  output logic              win_valid,
  output logic [31:0]       anchor_x,
  output logic [31:0]       anchor_y,
  output logic              anchor_moving,
  input  logic              filter_final,
  output logic              image_done,
  output logic [2:0]        dbg_state
);

  state_t              r_state;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [159:0]        r_win_pixels;
  logic                r_win_valid;
  logic [31:0]         r_anchor_x;
  logic [31:0]         r_anchor_y;
  logic                r_anchor_moving;
  logic                r_image_done;

  logic [SLOT_W-1:0]   w_slot;
  logic                w_slot_wrap;
  logic                w_slot_done;
  logic                w_slot_clear;
  logic [31:0]         w_gen_ax;
  logic [31:0]         w_gen_ay;
  logic [SLOT_W-1:0]   w_gen_slot;
  logic [ADDR_W-1:0]   w_gen_addr;
  logic                w_gen_in_range;
  logic [31:0]         w_next_ax;
  logic [31:0]         w_next_ay;
  logic                w_frame_end;
  pixel_t              w_pixel;

  // A slot completes on a read handshake, or immediately when it is skipped
  // (in FETCH, mem_req low means the current slot lies below the image).
  assign w_slot_done  = (r_state == FETCH) && (r_mem_req ? mem_ready : 1'b1);
  assign w_slot_clear = (((r_state == IDLE) || (r_state == DONE)) && start) ||
                        ((r_state == ADVANCE) && !w_frame_end);
  assign w_pixel      = r_mem_req ? mem_data : 8'h00;

  flex_counter #(
    .NUM_BITS (SLOT_W)
  ) u_slot_counter (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_clear        (w_slot_clear),
    .i_count_enable (w_slot_done),
    .i_rollover_val (LAST_SLOT),
    .o_count_out    (w_slot),
    .o_rollover_flag(w_slot_wrap)
  );

  // Next anchor in raster order and whether it falls off the image.
  always_comb begin
    w_next_ax = r_anchor_x + 32'(TILE_STEP);
    w_next_ay = r_anchor_y;
    if (w_next_ax == 32'(IMG_W)) begin
      w_next_ax = '0;
      w_next_ay = r_anchor_y + 32'(TILE_STEP);
    end
    w_frame_end = (w_next_ay == 32'(IMG_H));
  end

  // The address generator always looks at the slot that will be requested
  // next, so the request registers can be loaded one cycle ahead.
  always_comb begin
    w_gen_ax   = r_anchor_x;
    w_gen_ay   = r_anchor_y;
    w_gen_slot = w_slot + 1'b1;
    if ((r_state == IDLE) || (r_state == DONE)) begin
      w_gen_ax   = '0;
      w_gen_ay   = '0;
      w_gen_slot = '0;
    end else if (r_state == ADVANCE) begin
      w_gen_ax   = w_next_ax;
      w_gen_ay   = w_next_ay;
      w_gen_slot = '0;
    end
  end

  window_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_anchor_x (w_gen_ax),
    .i_anchor_y (w_gen_ay),
    .i_slot     (w_gen_slot),
    .i_base_addr(base_addr),
    .o_mem_addr (w_gen_addr),
    .o_in_range (w_gen_in_range)
  );

  // Main FSM with all outputs registered; mem_addr only moves when the next
  // slot is a real read, so skipped slots leave it at its previous value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_mem_req       <= 1'b0;
      r_mem_addr      <= '0;
      r_win_pixels    <= '0;
      r_win_valid     <= 1'b0;
      r_anchor_x      <= '0;
      r_anchor_y      <= '0;
      r_anchor_moving <= 1'b0;
      r_image_done    <= 1'b0;
    end else begin
      r_anchor_moving <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_anchor_x   <= '0;
            r_anchor_y   <= '0;
            r_image_done <= 1'b0;
            r_mem_req    <= w_gen_in_range;
            if (w_gen_in_range) r_mem_addr <= w_gen_addr;
            r_state      <= FETCH;
          end
        end
        FETCH: begin
          if (w_slot_done) begin
            r_win_pixels[{w_slot, 3'b000} +: 8] <= w_pixel;
            if (w_slot_wrap) begin
              r_mem_req       <= 1'b0;
              r_win_valid     <= 1'b1;
              r_anchor_moving <= 1'b1;
              r_state         <= PRESENT;
            end else begin
              r_mem_req <= w_gen_in_range;
              if (w_gen_in_range) r_mem_addr <= w_gen_addr;
            end
          end
        end
        PRESENT: begin
          if (filter_final) begin
            r_win_valid <= 1'b0;
            r_state     <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (w_frame_end) begin
            r_image_done <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_anchor_x <= w_next_ax;
            r_anchor_y <= w_next_ay;
            r_mem_req  <= w_gen_in_range;
            if (w_gen_in_range) r_mem_addr <= w_gen_addr;
            r_state    <= FETCH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req       = r_mem_req;
  assign mem_addr      = r_mem_addr;
  assign win_pixels    = r_win_pixels;
  assign win_valid     = r_win_valid;
  assign anchor_x      = r_anchor_x;
  assign anchor_y      = r_anchor_y;
  assign anchor_moving = r_anchor_moving;
  assign image_done    = r_image_done;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_window_fetcher.sv
// Bench for window_fetcher on an 8x8 image (4 windows per frame).
// Expected windows come from a direct slot -> (x, y) -> memory lookup model.
module tb_window_fetcher;
  import edge_pkg::*;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int ADDR_W = 20;
  localparam int NWIN   = (IMG_W / 4) * (IMG_H / 4);
  localparam int BOUND  = 3000;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_ready;
  logic [159:0]      win_pixels;
  logic              win_valid;
  logic [31:0]       anchor_x;
  logic [31:0]       anchor_y;
  logic              anchor_moving;
  logic              filter_final;
  logic              image_done;
  logic [2:0]        dbg_state;

  window_fetcher #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .win_pixels   (win_pixels),
    .win_valid    (win_valid),
    .anchor_x     (anchor_x),
    .anchor_y     (anchor_y),
    .anchor_moving(anchor_moving),
    .filter_final (filter_final),
    .image_done   (image_done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- shared state ----------------
  int errors = 0;
  int checks = 0;

  logic [7:0]   mem [0:4095];
  logic [159:0] exp_px_q[$];
  logic [31:0]  exp_ax_q[$];
  logic [31:0]  exp_ay_q[$];
  int           exp_rd_q[$];
  int           exp_cyc_q[$];

  int  stall_cfg    = 0;
  int  ff_delay_cfg = 2;
  bit  ff_hold      = 0;
  int  hs_cnt       = 0;
  int  req_cyc      = 0;
  int  win_seen     = 0;
  logic [159:0] first_px;
  logic [159:0] last_px;
  int  last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_px(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [159:0] model_window(input int ax, input int ay, input int base,
                                                output int nreads);
    logic [159:0] px;
    int y;
    int a;
    px     = '0;
    nreads = 0;
    for (int s = 0; s < 20; s++) begin
      y = ay + s / 4;
      if (y >= IMG_H) begin
`ifdef WINDOW_CLAMP_EN
        y = IMG_H - 1;
`else
        continue;
`endif
      end
      a = (base + y * IMG_W + ax + s % 4) % 4096;
      px[s*8 +: 8] = mem[a];
      nreads++;
    end
    return px;
  endfunction

  task automatic push_frame(input int base, input int stall);
    int n;
    logic [159:0] px;
    for (int ay = 0; ay < IMG_H; ay += 4) begin
      for (int ax = 0; ax < IMG_W; ax += 4) begin
        px = model_window(ax, ay, base, n);
        exp_px_q.push_back(px);
        exp_ax_q.push_back(32'(ax));
        exp_ay_q.push_back(32'(ay));
        exp_rd_q.push_back(n);
        exp_cyc_q.push_back(stall >= 0 ? (stall + 1) * n : -1);
      end
    end
  endtask

  task automatic flush_queues();
    exp_px_q.delete();
    exp_ax_q.delete();
    exp_ay_q.delete();
    exp_rd_q.delete();
    exp_cyc_q.delete();
  endtask

  // ---------------- memory responder (driver) ----------------
  initial begin : responder
    int wait_cnt;
    int need;
    logic [ADDR_W-1:0] held;
    mem_ready = 1'b0;
    mem_data  = '0;
    wait_cnt  = 0;
    need      = 0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        req_cyc++;
        if (wait_cnt == 0) begin
          held = mem_addr;
          need = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
        end else begin
          chk("addr_stable", 32'(mem_addr), 32'(held));
        end
        if (wait_cnt >= need) begin
          mem_ready = 1'b1;
          mem_data  = mem[mem_addr[11:0]];
          hs_cnt++;
          wait_cnt  = 0;
        end else begin
          mem_ready = 1'b0;
          mem_data  = 8'($urandom);
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        mem_data  = 8'($urandom);
        wait_cnt  = 0;
      end
    end
  end

  // ---------------- blur-stage driver ----------------
  initial begin : filter_drv
    int d;
    filter_final = 1'b0;
    forever begin
      @(negedge clk);
      if (ff_hold) begin
        filter_final = 1'b1;
      end else if (anchor_moving && !rst) begin
        d = (ff_delay_cfg < 0) ? int'($urandom_range(0, 3)) : ff_delay_cfg;
        repeat (d) @(negedge clk);
        filter_final = 1'b1;
        @(negedge clk);
        filter_final = 1'b0;
      end else begin
        filter_final = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic prev_am;
    prev_am = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && anchor_moving) begin
        chk("pulse_width", 32'(prev_am), 32'd0);
        if (exp_px_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: got anchor (%0d,%0d) expected none", anchor_x, anchor_y);
        end else begin
          chk("win_valid", 32'(win_valid), 32'd1);
          chk_px("win_pixels", win_pixels, exp_px_q.pop_front());
          chk("anchor_x", anchor_x, exp_ax_q.pop_front());
          chk("anchor_y", anchor_y, exp_ay_q.pop_front());
          chk("reads", 32'(hs_cnt), 32'(exp_rd_q[0]));
          if (exp_cyc_q[0] >= 0) chk("fetch_cycles", 32'(req_cyc), 32'(exp_cyc_q[0]));
          void'(exp_rd_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
        if (win_seen == 0) first_px = win_pixels;
        last_px = win_pixels;
        last_rd = hs_cnt;
        win_seen++;
        hs_cnt  = 0;
        req_cyc = 0;
      end
      prev_am = anchor_moving;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_frame(input int base, input int stall, input int ffd, input bit start_in_present);
    int cyc;
    stall_cfg    = stall;
    ff_delay_cfg = ffd;
    win_seen     = 0;
    hs_cnt       = 0;
    req_cyc      = 0;
    push_frame(base, stall);
    base_addr = ADDR_W'(base);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_mem_req", 32'(mem_req), 32'd1);
    chk("start_mem_addr", 32'(mem_addr), 32'(base));
    chk("start_done_clr", 32'(image_done), 32'd0);
    chk("start_anchor_x", anchor_x, 32'd0);
    chk("start_anchor_y", anchor_y, 32'd0);
    if (start_in_present) begin
      cyc = 0;
      while (!win_valid && cyc < BOUND) begin
        @(negedge clk);
        cyc++;
      end
      chk("present_reached", 32'(cyc < BOUND), 32'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (!image_done && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
    end
    chk("frame_done_in_time", 32'(cyc < BOUND), 32'd1);
    chk("queue_drained", 32'(exp_px_q.size()), 32'd0);
    chk("window_count", 32'(win_seen), 32'(NWIN));
    chk("done_anchor_x", anchor_x, 32'(IMG_W - 4));
    chk("done_anchor_y", anchor_y, 32'(IMG_H - 4));
    chk("done_win_valid", 32'(win_valid), 32'd0);
    flush_queues();
  endtask

  initial begin : main
    int cyc;
    logic [31:0] exp_row4;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
    repeat (2) @(negedge clk);

    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk_px("rst_win_pixels", win_pixels, '0);
    chk("rst_win_valid", 32'(win_valid), 32'd0);
    chk("rst_anchor_x", anchor_x, 32'd0);
    chk("rst_anchor_y", anchor_y, 32'd0);
    chk("rst_anchor_moving", 32'(anchor_moving), 32'd0);
    chk("rst_image_done", 32'(image_done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Basic frame: zero-wait memory, filter_final two cycles after each pulse.
    run_frame(0, 0, 2, 1'b0);
    chk("w00_slot5", 32'(first_px[47:40]), 32'd9);
`ifdef WINDOW_CLAMP_EN
    exp_row4 = {8'd63, 8'd62, 8'd61, 8'd60};
    chk("w44_reads", 32'(last_rd), 32'd20);
`else
    exp_row4 = 32'd0;
    chk("w44_reads", 32'(last_rd), 32'd16);
`endif
    chk("w44_row4", last_px[159:128], exp_row4);
    chk("done_level", 32'(image_done), 32'd1);

    // Three wait states per read, plus start pulsed during PRESENT.
    run_frame(0, 3, 2, 1'b1);
    chk_px("stall_same_w00", first_px, model_window(0, 0, 0, cyc));

    // filter_final held high, restart from DONE at a new base.
    ff_hold = 1'b1;
    run_frame(32'h100, 0, 0, 1'b0);
    ff_hold = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the second window's fetch.
    flush_queues();
    push_frame(0, 0);
    stall_cfg    = 0;
    ff_delay_cfg = 2;
    win_seen     = 0;
    hs_cnt       = 0;
    req_cyc      = 0;
    base_addr    = '0;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(win_seen == 1 && hs_cnt >= 10) && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
    end
    chk("reset_point_reached", 32'(cyc < BOUND), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk_px("arst_win_pixels", win_pixels, '0);
    chk("arst_win_valid", 32'(win_valid), 32'd0);
    chk("arst_anchor_x", anchor_x, 32'd0);
    chk("arst_anchor_y", anchor_y, 32'd0);
    chk("arst_image_done", 32'(image_done), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    flush_queues();
    @(negedge clk);
    run_frame(0, 0, 2, 1'b0);

    // Randomised frames: random memory, base, wait states and filter delay.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      run_frame(int'($urandom_range(0, 32'hF00)), -1, -1, 1'(k % 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
